// File: rtl/mem_access_ctrl.sv
// Single-access sequencer between the CPU datapath and the 16x16 block RAM.
// It latches one request, issues it to the RAM, waits out the read latency and acks.
module mem_access_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1   // legal range 1..3; the wait counter is 2 bits wide
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,   // active-high despite the name
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_en,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [1:0]        dbg_state
);

  // Handshake: a request is taken on any rising edge where cpu_req=1 and
  // cpu_ready=1; cpu_ack pulses for one cycle when the access has completed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = ACK;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        // douta is valid in the cycle the counter reaches zero
        if (cnt_q == 2'd0) begin
          rdata_d = ram_rd_data;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cpu_ready   = (state_q == IDLE);
  assign cpu_ack     = (state_q == ACK);
  assign cpu_rdata   = rdata_q;
  assign ram_en      = (state_q == ISSUE);
  assign ram_wea     = ram_en & we_q;
  assign ram_addr    = ram_en ? addr_q : '0;
  assign ram_wr_data = ram_wea ? wdata_q : '0;
  assign dbg_state   = state_q;

endmodule
